// File: rtl/wb_lsu_pkg.sv
// Shared types for the data-side load/store unit: funct3 codes,
// response causes, FSM states and the latched request bundle.
package wb_lsu_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'd0;
  localparam logic [2:0] FUNCT3_LH  = 3'd1;
  localparam logic [2:0] FUNCT3_LW  = 3'd2;
  localparam logic [2:0] FUNCT3_LBU = 3'd4;
  localparam logic [2:0] FUNCT3_LHU = 3'd5;
  localparam logic [2:0] FUNCT3_SB  = 3'd0;
  localparam logic [2:0] FUNCT3_SH  = 3'd1;
  localparam logic [2:0] FUNCT3_SW  = 3'd2;

  typedef enum logic [2:0] {
    LSU_CAUSE_OK         = 3'd0,
    LSU_CAUSE_MISALIGNED = 3'd1,
    LSU_CAUSE_ILLEGAL    = 3'd2,
    LSU_CAUSE_BUS_ERR    = 3'd3,
    LSU_CAUSE_RETRY_EXH  = 3'd4,
    LSU_CAUSE_TIMEOUT    = 3'd5
  } lsu_cause_e;

  typedef enum logic [1:0] {
    LSU_STATE_IDLE    = 2'd0,
    LSU_STATE_BUS     = 2'd1,
    LSU_STATE_BACKOFF = 2'd2,
    LSU_STATE_RESP    = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] off;
  } lsu_req_t;

endpackage

// File: rtl/wb_lsu_lane_steer.sv
// Byte-lane steering: store select/replication, load extraction and
// extension, plus alignment and funct3 legality checks.
module wb_lsu_lane_steer
  import wb_lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o
);

  logic [31:0] lane;

  assign lane = dat_i >> {off_i, 3'b000};

  always_comb begin
    sel_o        = 4'b1111;
    wdata_o      = wdata_i;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    if (we_i) begin
      case (funct3_i)
        FUNCT3_SB: begin
          sel_o   = 4'b0001 << off_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        FUNCT3_SH: begin
          sel_o        = off_i[1] ? 4'b1100 : 4'b0011;
          wdata_o      = {2{wdata_i[15:0]}};
          misaligned_o = off_i[0];
        end
        FUNCT3_SW: misaligned_o = |off_i;
        default:   illegal_o    = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        FUNCT3_LB,
        FUNCT3_LBU: misaligned_o = 1'b0;
        FUNCT3_LH,
        FUNCT3_LHU: misaligned_o = off_i[0];
        FUNCT3_LW:  misaligned_o = |off_i;
        default:    illegal_o    = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (funct3_i)
      FUNCT3_LB:  rdata_o = {{24{lane[7]}}, lane[7:0]};
      FUNCT3_LH:  rdata_o = {{16{lane[15]}}, lane[15:0]};
      FUNCT3_LW:  rdata_o = lane;
      FUNCT3_LBU: rdata_o = {24'd0, lane[7:0]};
      FUNCT3_LHU: rdata_o = {16'd0, lane[15:0]};
      default:    rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/wb_lsu.sv
// Wishbone B4 classic data-side load/store unit with retry,
// error and per-attempt timeout handling; all outputs registered.
module wb_lsu
  import wb_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [31:0]           rsp_rdata_o,
  output logic [2:0]            rsp_cause_o,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  input  logic                  ack_i,
  input  logic                  err_i,
  input  logic                  rty_i,
  output logic                  stb_o,
  output logic                  cyc_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [3:0]            sel_o
);

  localparam int RW = (MAX_RETRIES > 0) ?
                      $clog2(MAX_RETRIES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  lsu_state_e state_q, state_d;
  lsu_cause_e cause_d;
  lsu_req_t   req_q, req_d;

  logic [RW-1:0] rty_q, rty_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic                  ready_q, ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [2:0]            rsp_cause_q, rsp_cause_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [3:0]            sel_q, sel_d;
  logic [31:0]           dat_q, dat_d;

  logic        idle;
  logic        accept;
  logic        st_we;
  logic [2:0]  st_f3;
  logic [1:0]  st_off;
  logic [3:0]  st_sel;
  logic [31:0] st_wdata;
  logic [31:0] st_rdata;
  logic        st_mis;
  logic        st_ill;

  assign idle   = (state_q == LSU_STATE_IDLE);
  assign accept = req_valid_i && ready_q;

  // Steer from the live request while idle, else from the latched one
  assign st_we  = idle ? req_we_i          : req_q.we;
  assign st_f3  = idle ? req_funct3_i      : req_q.funct3;
  assign st_off = idle ? req_addr_i[1:0]   : req_q.off;

  wb_lsu_lane_steer u_steer (
    .we_i         (st_we),
    .funct3_i     (st_f3),
    .off_i        (st_off),
    .wdata_i      (req_wdata_i),
    .dat_i        (dat_i),
    .sel_o        (st_sel),
    .wdata_o      (st_wdata),
    .rdata_o      (st_rdata),
    .misaligned_o (st_mis),
    .illegal_o    (st_ill)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= LSU_STATE_IDLE;
      req_q       <= '0;
      rty_q       <= '0;
      tmo_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rty_q       <= rty_d;
      tmo_q       <= tmo_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_cause_q <= rsp_cause_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = LSU_CAUSE_OK;
    req_d   = req_q;
    rty_d   = rty_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      LSU_STATE_IDLE: begin
        if (accept) begin
          req_d.we     = req_we_i;
          req_d.funct3 = req_funct3_i;
          req_d.off    = req_addr_i[1:0];
          tmo_d        = '0;
          if (st_ill) begin
            state_d = LSU_STATE_RESP;
            cause_d = LSU_CAUSE_ILLEGAL;
          end else if (st_mis) begin
            state_d = LSU_STATE_RESP;
            cause_d = LSU_CAUSE_MISALIGNED;
          end else begin
            state_d = LSU_STATE_BUS;
          end
        end
      end
      LSU_STATE_BUS: begin
        if (err_i) begin
          state_d = LSU_STATE_RESP;
          cause_d = LSU_CAUSE_BUS_ERR;
        end else if (ack_i) begin
          state_d = LSU_STATE_RESP;
        end else if (rty_i) begin
          if (int'(rty_q) < MAX_RETRIES) begin
            rty_d   = rty_q + 1'b1;
            state_d = LSU_STATE_BACKOFF;
          end else begin
            state_d = LSU_STATE_RESP;
            cause_d = LSU_CAUSE_RETRY_EXH;
          end
        end else if (TIMEOUT_CYCLES > 0 &&
                     int'(tmo_q) == TIMEOUT_CYCLES) begin
          state_d = LSU_STATE_RESP;
          cause_d = LSU_CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      LSU_STATE_BACKOFF: begin
        tmo_d   = '0;
        state_d = LSU_STATE_BUS;
      end
      LSU_STATE_RESP: begin
        rty_d   = '0;
        state_d = LSU_STATE_IDLE;
      end
      default: state_d = LSU_STATE_IDLE;
    endcase
  end

  always_comb begin
    ready_d     = (state_d == LSU_STATE_IDLE);
    cyc_d       = (state_d == LSU_STATE_BUS);
    rsp_valid_d = (state_d == LSU_STATE_RESP);
    rsp_cause_d = rsp_valid_d ? cause_d : LSU_CAUSE_OK;
    rsp_rdata_d = '0;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    if (idle && state_d == LSU_STATE_BUS) begin
      we_d  = req_we_i;
      adr_d = {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
      sel_d = st_sel;
      dat_d = st_wdata;
    end
    if (state_q == LSU_STATE_BUS && rsp_valid_d &&
        cause_d == LSU_CAUSE_OK && !req_q.we) begin
      rsp_rdata_d = st_rdata;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_cause_o = rsp_cause_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_lsu.sv
// Directed bench for wb_lsu with MAX_RETRIES=2, TIMEOUT_CYCLES=4;
// inputs change and outputs are sampled 1 time unit after posedge.
module tb_wb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_cause;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        ack = 1'b0;
  logic        err = 1'b0;
  logic        rty = 1'b0;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;

  int n_cmp = 0;
  int n_bad = 0;

  wb_lsu #(
    .ADDR_WIDTH     (32),
    .MAX_RETRIES    (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_funct3_i (req_f3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_cause_o  (rsp_cause),
    .dat_i        (dat_i),
    .dat_o        (dat_o),
    .ack_i        (ack),
    .err_i        (err),
    .rty_i        (rty),
    .stb_o        (stb),
    .cyc_o        (cyc),
    .we_o         (we),
    .adr_o        (adr),
    .sel_o        (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = w;
    req_f3    = f3;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_cyc", {31'd0, cyc}, 0);
    chk("rst_stb", {31'd0, stb}, 0);
    chk("rst_rdy", {31'd0, req_ready}, 0);
    chk("rst_rsp", {31'd0, rsp_valid}, 0);
    chk("rst_adr", adr, 0);
    chk("rst_sel", {28'd0, sel}, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_cause", {29'd0, rsp_cause}, 0);
    tick();
    rst_n = 1'b1;
    chk("rdy_pre", {31'd0, req_ready}, 0);
    tick();
    chk("rdy_post", {31'd0, req_ready}, 1);

    // stray ack while idle is ignored
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("idle_ack", {31'd0, rsp_valid}, 0);

    // LB at 0x1003, sign extended
    issue(1'b0, 3'd0, 32'h1003, 32'd0);
    chk("lb_stb", {31'd0, stb}, 1);
    chk("lb_cyc", {31'd0, cyc}, 1);
    chk("lb_adr", adr, 32'h1000);
    chk("lb_sel", {28'd0, sel}, 32'hF);
    chk("lb_we", {31'd0, we}, 0);
    chk("lb_rdy", {31'd0, req_ready}, 0);
    dat_i = 32'h80FF_1234;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("lb_rsp", {31'd0, rsp_valid}, 1);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_cause", {29'd0, rsp_cause}, 0);
    chk("lb_cyc_off", {31'd0, cyc}, 0);
    tick();
    chk("lb_rsp_end", {31'd0, rsp_valid}, 0);
    chk("lb_rdy_end", {31'd0, req_ready}, 1);

    // SH 0xBEEF at 0x2002
    issue(1'b1, 3'd1, 32'h2002, 32'h0000_BEEF);
    chk("sh_sel", {28'd0, sel}, 32'hC);
    chk("sh_dat", dat_o, 32'hBEEF_BEEF);
    chk("sh_we", {31'd0, we}, 1);
    chk("sh_adr", adr, 32'h2000);
    dat_i = 32'h5555_5555;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("sh_rsp", {31'd0, rsp_valid}, 1);
    chk("sh_cause", {29'd0, rsp_cause}, 0);
    chk("sh_rdata", rsp_rdata, 0);
    tick();

    // SB 0xA5 at 0x5001
    issue(1'b1, 3'd0, 32'h5001, 32'h1234_56A5);
    chk("sb_sel", {28'd0, sel}, 32'h2);
    chk("sb_dat", dat_o, 32'hA5A5_A5A5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();

    // LW with two wait states
    issue(1'b0, 3'd2, 32'h4000, 32'd0);
    tick();
    chk("lw_w1_cyc", {31'd0, cyc}, 1);
    chk("lw_w1_rsp", {31'd0, rsp_valid}, 0);
    tick();
    chk("lw_w2_adr", adr, 32'h4000);
    dat_i = 32'hDEAD_BEEF;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("lw_rsp", {31'd0, rsp_valid}, 1);
    chk("lw_rdata", rsp_rdata, 32'hDEAD_BEEF);
    tick();

    // LHU upper half, LH lower half
    issue(1'b0, 3'd5, 32'h4002, 32'd0);
    dat_i = 32'h8001_7777;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("lhu_rdata", rsp_rdata, 32'h0000_8001);
    tick();
    issue(1'b0, 3'd1, 32'h4000, 32'd0);
    dat_i = 32'h1234_F00D;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("lh_rdata", rsp_rdata, 32'hFFFF_F00D);
    tick();

    // misaligned LW: immediate response, no bus cycle
    issue(1'b0, 3'd2, 32'h3001, 32'd0);
    chk("mis_rsp", {31'd0, rsp_valid}, 1);
    chk("mis_cause", {29'd0, rsp_cause}, 1);
    chk("mis_cyc", {31'd0, cyc}, 0);
    chk("mis_adr", adr, 32'h4000);
    tick();
    chk("mis_cyc2", {31'd0, cyc}, 0);
    chk("mis_rdy", {31'd0, req_ready}, 1);

    // illegal load funct3 and store funct3
    issue(1'b0, 3'd3, 32'h3000, 32'd0);
    chk("ill_ld_rsp", {31'd0, rsp_valid}, 1);
    chk("ill_ld_cause", {29'd0, rsp_cause}, 2);
    chk("ill_ld_cyc", {31'd0, cyc}, 0);
    tick();
    issue(1'b1, 3'd4, 32'h3000, 32'd0);
    chk("ill_st_cause", {29'd0, rsp_cause}, 2);
    tick();

    // two retries then ack
    issue(1'b0, 3'd2, 32'h6000, 32'd0);
    rty = 1'b1;
    tick();
    rty = 1'b0;
    chk("rt_gap1", {31'd0, cyc}, 0);
    tick();
    chk("rt_re1", {31'd0, cyc}, 1);
    rty = 1'b1;
    tick();
    rty = 1'b0;
    chk("rt_gap2", {31'd0, cyc}, 0);
    chk("rt_gap2_stb", {31'd0, stb}, 0);
    tick();
    chk("rt_re2", {31'd0, cyc}, 1);
    dat_i = 32'h1122_3344;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("rt_rsp", {31'd0, rsp_valid}, 1);
    chk("rt_cause", {29'd0, rsp_cause}, 0);
    chk("rt_rdata", rsp_rdata, 32'h1122_3344);
    tick();

    // three retries exhaust the budget
    issue(1'b0, 3'd2, 32'h6004, 32'd0);
    rty = 1'b1;
    tick();
    rty = 1'b0;
    tick();
    rty = 1'b1;
    tick();
    rty = 1'b0;
    tick();
    chk("rx_pre", {31'd0, rsp_valid}, 0);
    rty = 1'b1;
    tick();
    rty = 1'b0;
    chk("rx_rsp", {31'd0, rsp_valid}, 1);
    chk("rx_cause", {29'd0, rsp_cause}, 4);
    chk("rx_rdata", rsp_rdata, 0);
    tick();

    // err wins over ack
    issue(1'b0, 3'd2, 32'h7000, 32'd0);
    dat_i = 32'hFFFF_FFFF;
    err = 1'b1;
    ack = 1'b1;
    tick();
    err = 1'b0;
    ack = 1'b0;
    chk("err_rsp", {31'd0, rsp_valid}, 1);
    chk("err_cause", {29'd0, rsp_cause}, 3);
    chk("err_rdata", rsp_rdata, 0);
    tick();

    // timeout: counter 0..4 over five bus cycles
    issue(1'b1, 3'd2, 32'h8000, 32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_wait", {31'd0, rsp_valid}, 0);
      chk("to_dat", dat_o, 32'hCAFE_F00D);
    end
    tick();
    chk("to_rsp", {31'd0, rsp_valid}, 1);
    chk("to_cause", {29'd0, rsp_cause}, 5);
    chk("to_cyc", {31'd0, cyc}, 0);
    tick();

    // reset in the middle of a bus cycle
    issue(1'b0, 3'd2, 32'h9000, 32'd0);
    chk("mr_cyc", {31'd0, cyc}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_cyc_drop", {31'd0, cyc}, 0);
    chk("mr_stb_drop", {31'd0, stb}, 0);
    tick();
    rst_n = 1'b1;
    chk("mr_rsp", {31'd0, rsp_valid}, 0);
    tick();
    chk("mr_rdy", {31'd0, req_ready}, 1);
    chk("mr_rsp2", {31'd0, rsp_valid}, 0);
    chk("mr_cyc2", {31'd0, cyc}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
